approx_add_pipe: RTL and testbench

Parametrised, pipelined approximate unsigned adder with a run-time approximation level and a built-in error monitor. The low `mode_k` result bits are approximated (bitwise OR, no carry ripple), the upper bits are added exactly, and a carry propagates one `SEG`-bit segment per pipeline stage. An exact sum runs alongside each beat, so the block reports worst-case error and error count. It sits in the approximate-arithmetic evaluation fabric, between operand sources and consumers, using valid/ready streams.

---
 rtl/approx_add_pkg.sv | 34 +++
 rtl/approx_add_if.sv | 29 ++
 rtl/approx_add_seg.sv | 79 +++++++
 rtl/approx_add_pipe.sv | 123 ++++++++++++
 tb/tb_approx_add_pipe.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_add_pkg.sv
// Shared types and helpers for the pipelined approximate adder.
//   clamp_k   : limits a requested approximation level to the legal maximum
//   stages_f  : number of pipeline segments for a given width / segment size
//   mode_w_f  : width of the mode_k field for a given maximum level
//   stage_ctl_t : per-stage control payload (valid, both carries, K)
package approx_add_pkg;

  // Internal K container; wide enough for any K < WIDTH up to 255.
  localparam int unsigned KW = 8;
  typedef logic [KW-1:0] k_t;

  function automatic int unsigned mode_w_f(int unsigned approx_max);
    return $clog2(approx_max + 1);
  endfunction

  // mode_k width for the default configuration (APPROX_MAX = 8).
  localparam int unsigned ModeW = mode_w_f(8);

  typedef struct packed {
    logic valid;
    logic c_apx;  // carry of the approximate sum into the next segment
    logic c_ext;  // carry of the exact sum into the next segment
    k_t   k;      // effective approximation level of this beat
  } stage_ctl_t;

  function automatic k_t clamp_k(int unsigned mode, int unsigned kmax);
    return k_t'((mode > kmax) ? kmax : mode);
  endfunction

  function automatic int unsigned stages_f(int unsigned w, int unsigned s);
    return (w + s - 1) / s;
  endfunction

endpackage

// File: rtl/approx_add_if.sv
// Valid/ready operand and result streams of the approximate adder.
//   master : operand source / result consumer (drives in_*, a, b, mode_k, out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, err)
interface approx_add_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned APPROX_MAX = 8
);
  localparam int unsigned MW = approx_add_pkg::mode_w_f(APPROX_MAX);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [MW-1:0]    mode_k;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   err;

  modport master (
    output in_valid, a, b, mode_k, out_ready,
    input  in_ready, out_valid, sum, err
  );

  modport slave (
    input  in_valid, a, b, mode_k, out_ready,
    output in_ready, out_valid, sum, err
  );
endinterface

// File: rtl/approx_add_seg.sv
// One registered pipeline segment: adds bits [IDX*SEG +: SEG] of the operands,
// both exactly and approximately (bits below K are OR-ed with no carry chain).
//   clk, rst_n : clock, async active-low reset
//   en_i       : load enable (stage empty or draining)
//   ctl_i/o    : valid, carries and K
//   a/b_i/o    : operands, carried along for later segments
//   apx/ext_i/o: partial approximate / exact sums
module approx_add_seg
  import approx_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  stage_ctl_t       ctl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] apx_i,
  input  logic [WIDTH-1:0] ext_i,
  output stage_ctl_t       ctl_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] apx_o,
  output logic [WIDTH-1:0] ext_o
);
  localparam int unsigned Base = IDX * SEG;
  localparam int unsigned SegW = ((WIDTH - Base) < SEG) ? (WIDTH - Base) : SEG;

  stage_ctl_t       ctl_d, ctl_q;
  logic [WIDTH-1:0] apx_d, apx_q, ext_d, ext_q, a_q, b_q;
  logic             c_a, c_e;

  always_comb begin
    ctl_d = ctl_i;
    apx_d = apx_i;
    ext_d = ext_i;
    c_a   = ctl_i.c_apx;
    c_e   = ctl_i.c_ext;
    for (int unsigned j = 0; j < SegW; j++) begin
      ext_d[Base+j] = a_i[Base+j] ^ b_i[Base+j] ^ c_e;
      c_e = (a_i[Base+j] & b_i[Base+j]) | (c_e & (a_i[Base+j] ^ b_i[Base+j]));
      if ((Base + j) < 32'(ctl_i.k)) begin
        // Approximated bit: OR, and the carry into bit K is a[K-1] & b[K-1].
        apx_d[Base+j] = a_i[Base+j] | b_i[Base+j];
        c_a = a_i[Base+j] & b_i[Base+j];
      end else begin
        apx_d[Base+j] = a_i[Base+j] ^ b_i[Base+j] ^ c_a;
        c_a = (a_i[Base+j] & b_i[Base+j]) | (c_a & (a_i[Base+j] ^ b_i[Base+j]));
      end
    end
    ctl_d.c_apx = c_a;
    ctl_d.c_ext = c_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      apx_q <= '0;
      ext_q <= '0;
    end else if (en_i) begin
      ctl_q <= ctl_d;
      a_q   <= a_i;
      b_q   <= b_i;
      apx_q <= apx_d;
      ext_q <= ext_d;
    end
  end

  assign ctl_o = ctl_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign apx_o = apx_q;
  assign ext_o = ext_q;
endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder with error statistics.
//   clk, rst_n : clock, async active-low reset
//   bus        : operand / result valid-ready streams (slave side)
//   clr_stats  : synchronous clear of statistics (wins over a same-cycle beat)
//   err_max    : largest |exact - approximate| since last clear
//   err_cnt    : delivered beats with nonzero error (saturating)
//   beat_cnt   : delivered beats (saturating)
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SEG        = 4,
  parameter int unsigned APPROX_MAX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  approx_add_if.slave    bus,
  input  logic           clr_stats,
  output logic [WIDTH:0] err_max,
  output logic [31:0]    err_cnt,
  output logic [31:0]    beat_cnt
);
  localparam int unsigned Stages = stages_f(WIDTH, SEG);

  // Index s is the input of segment s; index s+1 is its registered output.
  stage_ctl_t       ctl_w [Stages+1];
  logic [WIDTH-1:0] a_w   [Stages+1];
  logic [WIDTH-1:0] b_w   [Stages+1];
  logic [WIDTH-1:0] apx_w [Stages+1];
  logic [WIDTH-1:0] ext_w [Stages+1];
  logic [Stages:0]  rdy;

  assign ctl_w[0] = '{valid: bus.in_valid, c_apx: 1'b0, c_ext: 1'b0,
                      k: clamp_k(32'(bus.mode_k), APPROX_MAX)};
  assign a_w[0]   = bus.a;
  assign b_w[0]   = bus.b;
  assign apx_w[0] = '0;
  assign ext_w[0] = '0;

  // Stall chain: a segment loads when its register is empty or drains this cycle.
  always_comb begin
    rdy = '0;
    rdy[Stages] = bus.out_ready;
    for (int s = int'(Stages) - 1; s >= 0; s--) begin
      rdy[s] = !ctl_w[s+1].valid | rdy[s+1];
    end
  end

  assign bus.in_ready = rdy[0];

  for (genvar s = 0; s < Stages; s++) begin : gen_seg
    approx_add_seg #(
      .WIDTH(WIDTH),
      .SEG  (SEG),
      .IDX  (s)
    ) u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .en_i (rdy[s]),
      .ctl_i(ctl_w[s]),
      .a_i  (a_w[s]),
      .b_i  (b_w[s]),
      .apx_i(apx_w[s]),
      .ext_i(ext_w[s]),
      .ctl_o(ctl_w[s+1]),
      .a_o  (a_w[s+1]),
      .b_o  (b_w[s+1]),
      .apx_o(apx_w[s+1]),
      .ext_o(ext_w[s+1])
    );
  end

  logic [WIDTH:0] sum_apx, sum_ext, err;

  assign sum_apx = {ctl_w[Stages].c_apx, apx_w[Stages]};
  assign sum_ext = {ctl_w[Stages].c_ext, ext_w[Stages]};
  assign err     = (sum_ext >= sum_apx) ? (sum_ext - sum_apx) : (sum_apx - sum_ext);

  assign bus.out_valid = ctl_w[Stages].valid;
  assign bus.sum       = sum_apx;
  assign bus.err       = err;

  // Operands and K are fully consumed by the last segment.
  logic unused_tail;
  assign unused_tail = ^{a_w[Stages], b_w[Stages], ctl_w[Stages].k};

  logic [WIDTH:0] err_max_d, err_max_q;
  logic [31:0]    err_cnt_d, err_cnt_q, beat_cnt_d, beat_cnt_q;
  logic           hs;

  assign hs = bus.out_valid & bus.out_ready;

  always_comb begin
    err_max_d  = err_max_q;
    err_cnt_d  = err_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (clr_stats) begin
      err_max_d  = '0;
      err_cnt_d  = '0;
      beat_cnt_d = '0;
    end else if (hs) begin
      if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 32'd1;
      if (err != '0 && err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
      if (err > err_max_q) err_max_d = err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_max_q  <= '0;
      err_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      err_max_q  <= err_max_d;
      err_cnt_q  <= err_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign err_max  = err_max_q;
  assign err_cnt  = err_cnt_q;
  assign beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe (WIDTH=16, SEG=4, APPROX_MAX=8).
module tb_approx_add_pipe;
  import approx_add_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr_stats;
  logic [16:0] err_max;
  logic [31:0] err_cnt, beat_cnt;

  approx_add_if #(.WIDTH(16), .APPROX_MAX(8)) dut_if ();

  approx_add_pipe #(
    .WIDTH     (16),
    .SEG       (4),
    .APPROX_MAX(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (dut_if.slave),
    .clr_stats(clr_stats),
    .err_max  (err_max),
    .err_cnt  (err_cnt),
    .beat_cnt (beat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [16:0] s;
    logic [16:0] e;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   out_cycs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   last_lat = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: low K bits OR-ed, upper bits added with carry a[K-1]&b[K-1].
  function automatic logic [16:0] apx_ref(logic [15:0] a, logic [15:0] b, int k);
    logic [16:0] mask, low, hi;
    if (k == 0) return 17'(a) + 17'(b);
    mask = (17'd1 << k) - 17'd1;
    low  = {1'b0, a | b} & mask;
    hi   = 17'(a >> k) + 17'(b >> k) + 17'(a[k-1] & b[k-1]);
    return (hi << k) | low;
  endfunction

  // Output monitor: every delivered beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && dut_if.out_valid && dut_if.out_ready) begin
      check_eq("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check_eq("sum", 64'(dut_if.sum), 64'(x.s));
        check_eq("err", 64'(dut_if.err), 64'(x.e));
        last_lat = cyc - x.acc_cyc;
        out_cycs.push_back(cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(logic [15:0] a, logic [15:0] b, logic [3:0] k,
                      logic [16:0] es, logic [16:0] ee);
    bit acc = 0;
    exp_t x;
    dut_if.in_valid = 1'b1;
    dut_if.a        = a;
    dut_if.b        = b;
    dut_if.mode_k   = k;
    for (int w = 0; w < 64 && !acc; w++) begin
      @(negedge clk);
      if (dut_if.in_ready) begin
        x = '{s: es, e: ee, acc_cyc: cyc};
        exp_q.push_back(x);
        n_acc++;
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    check_eq("send_accept", 64'(acc), 64'd1);
    dut_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 64 && exp_q.size() != 0; w++) @(negedge clk);
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    bit seen = 0;
    for (int w = 0; w < 32 && !seen; w++) begin
      @(negedge clk);
      seen = dut_if.out_valid;
    end
    check_eq("out_valid_wait", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    clr_stats        = 1'b0;
    dut_if.in_valid  = 1'b0;
    dut_if.a         = '0;
    dut_if.b         = '0;
    dut_if.mode_k    = '0;
    dut_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
    check_eq("rst_sum", 64'(dut_if.sum), 64'd0);
    check_eq("rst_err", 64'(dut_if.err), 64'd0);
    check_eq("rst_in_ready", 64'(dut_if.in_ready), 64'd1);
    check_eq("rst_stats", 64'({err_max, err_cnt, beat_cnt}), 64'd0);
    @(posedge clk);
    #1;

    // Exact add with full carry-out.
    send(16'hFFFF, 16'h0001, 4'd0, 17'h10000, 17'd0);
    drain();
    check_eq("latency", 64'(last_lat), 64'd4);
    check_eq("s1_beat_cnt", 64'(beat_cnt), 64'd1);
    check_eq("s1_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("s1_err_max", 64'(err_max), 64'd0);

    // K=8: lost carry, then carry from bit 7 into bit 8.
    send(16'h00FF, 16'h0001, 4'd8, 17'h000FF, 17'd1);
    send(16'h0080, 16'h0080, 4'd8, 17'h00180, 17'd128);
    drain();
    check_eq("s2_err_max", 64'(err_max), 64'd128);
    check_eq("s2_err_cnt", 64'(err_cnt), 64'd2);
    check_eq("s2_beat_cnt", 64'(beat_cnt), 64'd3);

    // mode_k above APPROX_MAX clamps to 8.
    send(16'h00FF, 16'h0001, 4'd15, 17'h000FF, 17'd1);
    drain();
    check_eq("s3_err_cnt", 64'(err_cnt), 64'd3);

    // Back-pressure: 4 beats fill the pipe, rest wait; all 6 emerge back to back.
    dut_if.out_ready = 1'b0;
    n_acc = 0;
    out_cycs.delete();
    fork
      begin
        send(16'h0001, 16'h0002, 4'd0, 17'h00003, 17'd0);
        send(16'h1234, 16'h1111, 4'd0, 17'h02345, 17'd0);
        send(16'hFFFF, 16'hFFFF, 4'd0, 17'h1FFFE, 17'd0);
        send(16'h8000, 16'h8000, 4'd0, 17'h10000, 17'd0);
        send(16'h00F0, 16'h0F0F, 4'd0, 17'h00FFF, 17'd0);
        send(16'h000F, 16'h0001, 4'd4, 17'h0000F, 17'd1);
      end
    join_none
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("stall_accepted", 64'(n_acc), 64'd4);
    check_eq("stall_in_ready", 64'(dut_if.in_ready), 64'd0);
    check_eq("stall_out_valid", 64'(dut_if.out_valid), 64'd1);
    check_eq("stall_sum_hold", 64'(dut_if.sum), 64'h3);
    @(posedge clk);
    #1 dut_if.out_ready = 1'b1;
    wait fork;
    drain();
    check_eq("stall_count", 64'(out_cycs.size()), 64'd6);
    if (out_cycs.size() == 6) check_eq("stall_rate", 64'(out_cycs[5] - out_cycs[0]), 64'd5);

    // Alternating K=0 / K=8 with random operands against the reference.
    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra, rb;
      logic [16:0] es, ex, ee;
      int k;
      ra = 16'($urandom);
      rb = 16'($urandom);
      k  = (i % 2 == 0) ? 0 : 8;
      es = apx_ref(ra, rb, k);
      ex = 17'(ra) + 17'(rb);
      ee = (ex >= es) ? ex - es : es - ex;
      send(ra, rb, 4'(k), es, ee);
    end
    drain();

    // Clear coinciding with an erroneous handshake: clear wins.
    dut_if.out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 4'd8, 17'h000FF, 17'd1);
    wait_out_valid();
    check_eq("pre_clr_nz", 64'(err_cnt != 0), 64'd1);
    clr_stats        = 1'b1;
    dut_if.out_ready = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    check_eq("clr_beat_cnt", 64'(beat_cnt), 64'd0);
    check_eq("clr_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("clr_err_max", 64'(err_max), 64'd0);
    check_eq("clr_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream discards beats and statistics asynchronously.
    send(16'h0080, 16'h0080, 4'd8, 17'h00180, 17'd128);
    drain();
    check_eq("pre_rst_beat_cnt", 64'(beat_cnt), 64'd1);
    check_eq("pre_rst_err_max", 64'(err_max), 64'd128);
    dut_if.out_ready = 1'b0;
    send(16'h0003, 16'h0004, 4'd0, 17'h00007, 17'd0);
    send(16'h00FF, 16'h0001, 4'd8, 17'h000FF, 17'd1);
    wait_out_valid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(dut_if.out_valid), 64'd0);
    check_eq("arst_sum", 64'(dut_if.sum), 64'd0);
    check_eq("arst_stats", 64'({err_max, err_cnt, beat_cnt}), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    dut_if.out_ready = 1'b1;
    check_eq("post_rst_in_ready", 64'(dut_if.in_ready), 64'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_empty", 64'(dut_if.out_valid), 64'd0);
    @(posedge clk);
    #1;
    send(16'h0F0F, 16'h00F1, 4'd4, 17'h00FFF, 17'd1);
    drain();
    check_eq("post_rst_beat_cnt", 64'(beat_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
